// File: rtl/serial_parity_pkg.sv
// Shared types for the serial parity transmitter.
// Define SERIAL_PARITY_TX_ODD_EN for odd parity; even parity otherwise.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } tx_state_t;

  localparam logic PARITY_IDLE_LEVEL = 1'b0;

`ifdef SERIAL_PARITY_TX_ODD_EN
  localparam logic PARITY_ODD = 1'b1;
`else
  localparam logic PARITY_ODD = 1'b0;
`endif

endpackage

// File: rtl/serial_parity_tx.sv
// LSB-first serial transmitter appending one parity bit per frame.
// Parity sense is set by SERIAL_PARITY_TX_ODD_EN (odd) or left even.
module serial_parity_tx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              tx_valid,
  output logic              tx_last
);

  localparam int CW = $clog2(DATA_W + 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] sh_nxt;
  logic              acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept;

  assign ready    = (state_q == S_IDLE) || (state_q == S_PAR);
  assign tx_valid = (state_q == S_DATA) || (state_q == S_PAR);
  assign tx_last  = (state_q == S_PAR);
  assign accept   = load & ready;
  assign sh_nxt   = shreg_q >> 1;

  always_comb begin
    tx = PARITY_IDLE_LEVEL;
    unique case (state_q)
      S_DATA:  tx = shreg_q[0];
      S_PAR:   tx = acc_q ^ PARITY_ODD;
      default: tx = PARITY_IDLE_LEVEL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_PAR: begin
        if (accept) begin
          shreg_d = data_in;
          acc_d   = data_in[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        // acc picks up each bit as it reaches the LSB
        shreg_d = sh_nxt;
        acc_d   = acc_q ^ sh_nxt[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1))
          state_d = S_PAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench for serial_parity_tx: a frame-level model queues
// expected bits on accept; a monitor compares on every valid cycle.
module tb_serial_parity_tx;

  localparam int DW = 8;
`ifdef SERIAL_PARITY_TX_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          load = 1'b0;
  logic          ready, tx, tx_valid, tx_last;

  int checks = 0;
  int failures = 0;

  exp_t q[$];
  int   rem = 0;
  int   runlen = 0;
  int   maxrun = 0;
  logic fxor = 1'b0;

  serial_parity_tx #(.DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .load(load),
    .ready(ready),
    .tx(tx),
    .tx_valid(tx_valid),
    .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Frame model: a busy window of DW+1 cycles whose last cycle can accept.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      rem = 0;
    end else if (load && rem <= 1) begin
      for (int i = 0; i < DW; i++)
        q.push_back('{b: data_in[i], last: 1'b0});
      q.push_back('{b: (^data_in) ^ ODD, last: 1'b1});
      rem = DW + 1;
    end else if (rem > 0) begin
      rem = rem - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("ready", ready, (rem <= 1));
    if (tx_valid) begin
      runlen++;
      if (runlen > maxrun) maxrun = runlen;
      if (q.size() == 0) begin
        chk("unexpected_valid", tx_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("tx_bit", tx, e.b);
        chk("tx_last", tx_last, e.last);
        fxor = fxor ^ tx;
        if (tx_last) begin
          chk("loopback_parity", fxor, ODD);
          fxor = 1'b0;
        end
      end
    end else begin
      runlen = 0;
      fxor = 1'b0;
      chk("idle_tx", {tx, tx_last}, 2'b00);
    end
  end

  task automatic send1(input logic [DW-1:0] d);
    @(negedge clk);
    load = 1'b1;
    data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_tx", tx, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_last", tx_last, 1'b0);
    idle(2);
    reset = 1'b0;

    send1(8'hA5);
    idle(10);
    send1(8'h07);
    idle(10);

    maxrun = 0;
    @(negedge clk);
    load = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    data_in = 8'h07;
    idle(9);
    load = 1'b0;
    idle(12);
    chk("b2b_run", maxrun, 18);

    send1(8'hA5);
    idle(2);
    send1(8'hFF);
    idle(10);
    chk("ignored_done", q.size(), 0);

    send1(8'hA5);
    idle(3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b0);
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    idle(2);
    reset = 1'b0;
    send1(8'h3C);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 2) == 0);
      data_in = DW'($urandom);
    end
    load = 1'b0;
    idle(2 * (DW + 2));
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_parity_tx.md
# serial_parity_tx

Serial parity transmitter: accepts a parallel word on a valid/ready handshake and shifts it out LSB-first, one bit per clock, followed by one parity bit. It is the transmit end of the single-bit serial parity link, and its `tx` output drives the serial input `x` of the team's Moore parity checker. With even parity, the checker's `parity` output reads 0 immediately after a complete frame.

## Interface
- `DATA_W`, default 8: payload bits per frame; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_W  payload word; sampled only on the accept edge.
- `load`  in  1  request to send `data_in`.
- `ready`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial bit stream; 0 when idle.
- `tx_valid`  out  1  `tx` carries a frame bit this cycle.
- `tx_last`  out  1  `tx` carries the parity bit this cycle.

## Operation
- Three-state Moore FSM; all outputs are decoded from registered state, shift register and parity accumulator.
  - `S_IDLE`: waiting for a word.
  - `S_DATA`: shifting out payload bits.
  - `S_PAR`: sending the parity bit.
- Accept occurs on a clock edge where `load && ready`. On accept:
  - `shreg <= data_in`
  - `acc <= data_in[0]`
  - `cnt <= 0`
  - state → `S_DATA`
- `S_DATA` outputs:
  - `tx = shreg[0]`, `tx_valid = 1`, `ready = 0`.
- `S_DATA` on each edge:
  - shift `shreg` right;
  - XOR the new `shreg[0]` into `acc`;
  - `cnt++`.
  - When `cnt == DATA_W-1`, go to `S_PAR` (`acc` now holds the XOR of all payload bits).
- `S_PAR` outputs:
  - `tx` = parity bit (`acc` for even parity; see Configuration);
  - `tx_valid = 1`, `tx_last = 1`, `ready = 1`.
- `S_PAR` exit:
  - if `load` is high, accept the new word and go to `S_DATA` (back-to-back frames, no idle gap);
  - otherwise go to `S_IDLE`.
- `S_IDLE` outputs: `tx = 0`, `tx_valid = 0`, `tx_last = 0`, `ready = 1`.
- `load` while `ready = 0` is ignored; the frame in progress is unaffected and `data_in` is not sampled.
- `cnt` width is `$clog2(DATA_W+1)`; no wrap is possible. `DATA_W = 1` gives a 2-bit frame: one payload bit, then parity.

## Timing
- Reset (asynchronous, immediate):
  - state `S_IDLE`; `shreg`, `acc`, `cnt` = 0;
  - outputs `ready = 1`, `tx = 0`, `tx_valid = 0`, `tx_last = 0`.
- Reset mid-frame aborts the frame with no parity bit sent. The first edge after reset deasserts may accept a word.
- Frame timing, with the accept at edge k:
  - payload bit i is on `tx` during cycle k+i, for i = 0..DATA_W-1;
  - the parity bit is on `tx` during cycle k+DATA_W.
- Frame length is DATA_W+1 cycles. Latency from accept to first bit is 1 edge.
- Sustained throughput is one frame every DATA_W+1 cycles when `load` is held high.

## Configuration
- `SERIAL_PARITY_TX_ODD_EN` defined: parity bit = `~acc` (odd parity). The full-frame XOR is 1.
- Not defined: parity bit = `acc` (even parity). The full-frame XOR is 0. This is the default, matching the checker's S0-after-frame convention.

## Structure
- Package `serial_parity_pkg` holds:
  - `typedef enum` `tx_state_t` {`S_IDLE`, `S_DATA`, `S_PAR`};
  - localparam `PARITY_IDLE_LEVEL = 1'b0`.
- No sub-module; the FSM, shift register, counter and accumulator are a single module.

## Test plan
- Reset, then `load=1`, `data_in=8'hA5` at edge k:
  - `tx` over cycles k..k+8 = 1,0,1,0,0,1,0,1, then 0;
  - `tx_last` high only at k+8; `ready` low during k..k+7.
- `data_in=8'h07`: parity bit = 1. Loopback into the parity checker: its output is 0 after the frame.
- Hold `load=1` with A5 then 07:
  - second frame's bit 0 appears at k+9;
  - `tx_valid` stays high for 18 consecutive cycles.
- `load=1` with `data_in=8'hFF` at cycle k+3 of an A5 frame: ignored; the A5 frame completes unchanged and the block returns to `S_IDLE`.
- Assert `reset` at cycle k+4 of a frame:
  - `tx`, `tx_valid` drop to 0 and `ready` rises with no clock edge;
  - the next accepted word (`8'h3C`) transmits correctly.
- With `SERIAL_PARITY_TX_ODD_EN` defined: A5 gives parity 1 and 07 gives parity 0; with `DATA_W=1`, `data_in=1` gives frame 1,0.
